altera_up_video_alpha_inserter: RTL and testbench

- Converts a 30-bit RGB video stream into the 40-bit {alpha, R, G, B} foreground stream consumed by the alpha blending stage.
- Alpha is derived per pixel from a programmable chroma key and an opacity value. Both are set through a small Avalon-MM slave.
- Configuration changes take effect only at frame boundaries.
- Sits directly upstream of the blender's foreground input. Fed by a pixel buffer DMA / RGB resampler.

---
 rtl/altera_up_video_alpha_pkg.sv | 42 ++++
 rtl/altera_up_video_alpha_inserter_csr.sv | 91 +++++++++
 rtl/altera_up_video_alpha_inserter.sv | 125 ++++++++++++
 tb/tb_altera_up_video_alpha_inserter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/altera_up_video_alpha_pkg.sv
// Shared constants, pixel layout and the alpha decision rule for the video alpha inserter.
// Both the CSR block and the pipeline top import this package.
package altera_up_video_alpha_pkg;

   localparam int COLOR_W = 10;
   localparam int ALPHA_W = 10;
   localparam int RGB_W   = 3 * COLOR_W;

   localparam logic [1:0] ADDR_CTRL    = 2'd0;
   localparam logic [1:0] ADDR_KEY     = 2'd1;
   localparam logic [1:0] ADDR_OPACITY = 2'd2;
   localparam logic [1:0] ADDR_STATUS  = 2'd3;

   localparam int CTRL_KEY_EN   = 0;
   localparam int CTRL_BLEND_EN = 1;

   localparam logic [ALPHA_W-1:0] ALPHA_OPAQUE = '1;
   localparam logic [ALPHA_W-1:0] ALPHA_CLEAR  = '0;

   typedef struct packed {
      logic [ALPHA_W-1:0] alpha;
      logic [COLOR_W-1:0] r;
      logic [COLOR_W-1:0] g;
      logic [COLOR_W-1:0] b;
   } argb_t;

   // Blending off forces opaque; a key hit punches a fully transparent hole.
   function automatic logic [ALPHA_W-1:0] compute_alpha(
      input logic [1:0]         ctrl,
      input logic [RGB_W-1:0]   key,
      input logic [ALPHA_W-1:0] opacity,
      input logic [RGB_W-1:0]   rgb
   );
      if (!ctrl[CTRL_BLEND_EN])
         return ALPHA_OPAQUE;
      else if (ctrl[CTRL_KEY_EN] && (rgb == key))
         return ALPHA_CLEAR;
      else
         return opacity;
   endfunction

endpackage

// File: rtl/altera_up_video_alpha_inserter_csr.sv
// Avalon-MM slave for the alpha inserter: pending configuration registers, registered
// read mux, and per-frame status (in_frame flag, 16-bit wrapping frame counter).
module altera_up_video_alpha_inserter_csr
   import altera_up_video_alpha_pkg::*;
#(
   parameter logic [RGB_W-1:0]   DEFAULT_KEY     = '0,
   parameter logic [ALPHA_W-1:0] DEFAULT_OPACITY = '1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         address,
   input  logic               chipselect,
   input  logic               read,
   input  logic               write,
   input  logic [31:0]        writedata,
   input  logic               beat_accept,
   input  logic               beat_sop,
   input  logic               beat_eop,
   output logic [31:0]        readdata,
   output logic [1:0]         pend_ctrl,
   output logic [RGB_W-1:0]   pend_key,
   output logic [ALPHA_W-1:0] pend_opacity
);

   logic        csr_write;
   logic        status_write;
   logic [15:0] frame_count;
   logic        in_frame;
   logic [31:0] read_mux;
   logic        unused_wdata;

   assign csr_write    = chipselect & write;
   assign status_write = csr_write & (address == ADDR_STATUS);
   assign unused_wdata = ^writedata[31:RGB_W];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_ctrl    <= 2'b11;
         pend_key     <= DEFAULT_KEY;
         pend_opacity <= DEFAULT_OPACITY;
      end else if (csr_write) begin
         case (address)
            ADDR_CTRL:    pend_ctrl    <= writedata[1:0];
            ADDR_KEY:     pend_key     <= writedata[RGB_W-1:0];
            ADDR_OPACITY: pend_opacity <= writedata[ALPHA_W-1:0];
            default:      ;
         endcase
      end
   end

   // A status write beats a same-cycle eop so software always sees a clean zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_count <= '0;
         in_frame    <= 1'b0;
      end else begin
         if (status_write)
            frame_count <= '0;
         else if (beat_accept && beat_eop)
            frame_count <= frame_count + 16'd1;

         if (beat_accept) begin
            if (beat_eop)
               in_frame <= 1'b0;
            else if (beat_sop)
               in_frame <= 1'b1;
         end
      end
   end

   // NOTE: every always_comb output gets a default first so no latch can be inferred.
   always_comb begin
      read_mux = '0;
      case (address)
         ADDR_CTRL:    read_mux = {30'd0, pend_ctrl};
         ADDR_KEY:     read_mux = {{(32-RGB_W){1'b0}}, pend_key};
         ADDR_OPACITY: read_mux = {{(32-ALPHA_W){1'b0}}, pend_opacity};
         ADDR_STATUS:  read_mux = {frame_count, 15'd0, in_frame};
         default:      read_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         readdata <= '0;
      else if (chipselect && read)
         readdata <= read_mux;
   end

endmodule

// File: rtl/altera_up_video_alpha_inserter.sv
// 30-bit RGB to 40-bit ARGB stream stage with chroma-key / opacity alpha and one register of latency.
// Optional macro ALPHA_INSERTER_FADE_EN ramps the active opacity toward the pending value by FADE_STEP per frame.
module altera_up_video_alpha_inserter
   import altera_up_video_alpha_pkg::*;
#(
   parameter logic [RGB_W-1:0]   DEFAULT_KEY     = 30'h0000000,
   parameter logic [ALPHA_W-1:0] DEFAULT_OPACITY = 10'h3FF,
   parameter logic [ALPHA_W-1:0] FADE_STEP       = 10'h020
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [RGB_W-1:0]   stream_in_data,
   input  logic               stream_in_startofpacket,
   input  logic               stream_in_endofpacket,
   input  logic [1:0]         stream_in_empty,
   input  logic               stream_in_valid,
   output logic               stream_in_ready,
   output logic [39:0]        stream_out_data,
   output logic               stream_out_startofpacket,
   output logic               stream_out_endofpacket,
   output logic [1:0]         stream_out_empty,
   output logic               stream_out_valid,
   input  logic               stream_out_ready,
   input  logic [1:0]         address,
   input  logic               chipselect,
   input  logic               read,
   input  logic               write,
   input  logic [31:0]        writedata,
   output logic [31:0]        readdata
);

   logic               accept;
   logic [1:0]         pend_ctrl;
   logic [RGB_W-1:0]   pend_key;
   logic [ALPHA_W-1:0] pend_opacity;
   logic [1:0]         act_ctrl;
   logic [RGB_W-1:0]   act_key;
   logic [ALPHA_W-1:0] act_opacity;
   logic [ALPHA_W-1:0] next_opacity;
   logic [1:0]         sel_ctrl;
   logic [RGB_W-1:0]   sel_key;
   logic [ALPHA_W-1:0] sel_opacity;
   argb_t              out_pixel;
   logic               unused_empty;

   assign stream_in_ready  = ~stream_out_valid | stream_out_ready;
   assign accept           = stream_in_valid & stream_in_ready;
   assign stream_out_data  = out_pixel;
   assign stream_out_empty = 2'h0;
   assign unused_empty     = ^stream_in_empty;

   altera_up_video_alpha_inserter_csr #(
      .DEFAULT_KEY     (DEFAULT_KEY),
      .DEFAULT_OPACITY (DEFAULT_OPACITY)
   ) u_csr (
      .clk          (clk),
      .reset        (reset),
      .address      (address),
      .chipselect   (chipselect),
      .read         (read),
      .write        (write),
      .writedata    (writedata),
      .beat_accept  (accept),
      .beat_sop     (stream_in_startofpacket),
      .beat_eop     (stream_in_endofpacket),
      .readdata     (readdata),
      .pend_ctrl    (pend_ctrl),
      .pend_key     (pend_key),
      .pend_opacity (pend_opacity)
   );

`ifdef ALPHA_INSERTER_FADE_EN
   always_comb begin
      next_opacity = pend_opacity;
      if (pend_opacity > act_opacity) begin
         if ((pend_opacity - act_opacity) > FADE_STEP)
            next_opacity = act_opacity + FADE_STEP;
      end else if (act_opacity > pend_opacity) begin
         if ((act_opacity - pend_opacity) > FADE_STEP)
            next_opacity = act_opacity - FADE_STEP;
      end
   end
`else
   logic unused_fade;
   assign unused_fade  = ^FADE_STEP;
   assign next_opacity = pend_opacity;
`endif

   // The sop beat already sees the configuration it is about to latch into the active set.
   assign sel_ctrl    = stream_in_startofpacket ? pend_ctrl    : act_ctrl;
   assign sel_key     = stream_in_startofpacket ? pend_key     : act_key;
   assign sel_opacity = stream_in_startofpacket ? next_opacity : act_opacity;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         act_ctrl    <= 2'b11;
         act_key     <= DEFAULT_KEY;
         act_opacity <= DEFAULT_OPACITY;
      end else if (accept && stream_in_startofpacket) begin
         act_ctrl    <= pend_ctrl;
         act_key     <= pend_key;
         act_opacity <= next_opacity;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stream_out_valid         <= 1'b0;
         stream_out_startofpacket <= 1'b0;
         stream_out_endofpacket   <= 1'b0;
         out_pixel                <= '0;
      end else if (accept) begin
         stream_out_valid         <= 1'b1;
         stream_out_startofpacket <= stream_in_startofpacket;
         stream_out_endofpacket   <= stream_in_endofpacket;
         out_pixel.alpha          <= compute_alpha(sel_ctrl, sel_key, sel_opacity, stream_in_data);
         out_pixel.r              <= stream_in_data[29:20];
         out_pixel.g              <= stream_in_data[19:10];
         out_pixel.b              <= stream_in_data[9:0];
      end else if (stream_out_ready) begin
         stream_out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_altera_up_video_alpha_inserter.sv
// Directed self-checking bench for altera_up_video_alpha_inserter (default build, fade macro undefined).
module tb_altera_up_video_alpha_inserter;

   logic        clk = 1'b0;
   logic        reset;
   logic [29:0] stream_in_data;
   logic        stream_in_startofpacket;
   logic        stream_in_endofpacket;
   logic [1:0]  stream_in_empty;
   logic        stream_in_valid;
   logic        stream_in_ready;
   logic [39:0] stream_out_data;
   logic        stream_out_startofpacket;
   logic        stream_out_endofpacket;
   logic [1:0]  stream_out_empty;
   logic        stream_out_valid;
   logic        stream_out_ready;
   logic [1:0]  address;
   logic        chipselect;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   altera_up_video_alpha_inserter dut (
      .clk                      (clk),
      .reset                    (reset),
      .stream_in_data           (stream_in_data),
      .stream_in_startofpacket  (stream_in_startofpacket),
      .stream_in_endofpacket    (stream_in_endofpacket),
      .stream_in_empty          (stream_in_empty),
      .stream_in_valid          (stream_in_valid),
      .stream_in_ready          (stream_in_ready),
      .stream_out_data          (stream_out_data),
      .stream_out_startofpacket (stream_out_startofpacket),
      .stream_out_endofpacket   (stream_out_endofpacket),
      .stream_out_empty         (stream_out_empty),
      .stream_out_valid         (stream_out_valid),
      .stream_out_ready         (stream_out_ready),
      .address                  (address),
      .chipselect               (chipselect),
      .read                     (read),
      .write                    (write),
      .writedata                (writedata),
      .readdata                 (readdata)
   );

   // One beat offered with the sink ready; returns #1 after the accepting edge.
   task automatic beat(input logic [29:0] d, input logic s, input logic e);
      stream_in_valid         = 1'b1;
      stream_in_data          = d;
      stream_in_startofpacket = s;
      stream_in_endofpacket   = e;
      @(posedge clk); #1;
      stream_in_valid         = 1'b0;
      stream_in_startofpacket = 1'b0;
      stream_in_endofpacket   = 1'b0;
   endtask

   task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      @(posedge clk); #1;
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
      chipselect = 1'b1; read = 1'b1; address = a;
      @(posedge clk); #1;
      chipselect = 1'b0; read = 1'b0;
      d = readdata;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      #2;
      checks++; if ({stream_out_valid, stream_out_startofpacket, stream_out_endofpacket} !== 3'b000) begin
         $display("FAIL reset_flags: got %b expected 000", {stream_out_valid, stream_out_startofpacket, stream_out_endofpacket}); failures++; end
      checks++; if (stream_out_data !== 40'h0) begin
         $display("FAIL reset_data: got %h expected 0", stream_out_data); failures++; end
      checks++; if (readdata !== 32'h0 || stream_out_empty !== 2'h0) begin
         $display("FAIL reset_readdata_empty: got %h/%h expected 0/0", readdata, stream_out_empty); failures++; end
      @(posedge clk); #1 reset = 1'b1;
      csr_read(2'd0, rd);
      checks++; if (rd !== 32'h3) begin $display("FAIL reset_ctrl: got %h expected 3", rd); failures++; end
      csr_read(2'd1, rd);
      checks++; if (rd !== 32'h0) begin $display("FAIL reset_key: got %h expected 0", rd); failures++; end
      csr_read(2'd2, rd);
      checks++; if (rd !== 32'h3FF) begin $display("FAIL reset_opacity: got %h expected 3ff", rd); failures++; end
      csr_read(2'd3, rd);
      checks++; if (rd !== 32'h0) begin $display("FAIL reset_status: got %h expected 0", rd); failures++; end
   endtask

   task automatic test_default_frame();
      logic [29:0] pix [4];
      logic [9:0]  alp [4];
      pix = '{30'h3FF00000, 30'h0, 30'h0, 30'h12345};
      alp = '{10'h3FF, 10'h000, 10'h000, 10'h3FF};
      checks++; if (stream_out_valid !== 1'b0) begin
         $display("FAIL frame_idle_valid: got %b expected 0", stream_out_valid); failures++; end
      for (int i = 0; i < 4; i++) begin
         beat(pix[i], i == 0, i == 3);
         checks++; if ({stream_out_valid, stream_out_startofpacket, stream_out_endofpacket, stream_out_data} !==
                       {1'b1, i == 0, i == 3, alp[i], pix[i]}) begin
            $display("FAIL default_frame_beat%0d: got %b%b%b_%h expected 1%b%b_%h", i, stream_out_valid,
                     stream_out_startofpacket, stream_out_endofpacket, stream_out_data, i == 0, i == 3, {alp[i], pix[i]});
            failures++; end
      end
      @(posedge clk); #1;
      checks++; if (stream_out_valid !== 1'b0) begin
         $display("FAIL frame_drain_valid: got %b expected 0", stream_out_valid); failures++; end
   endtask

   task automatic test_opacity_midframe();
      logic [31:0] rd;
      logic [29:0] pix [7];
      logic [9:0]  alp [7];
      pix = '{30'h1, 30'h2, 30'h3, 30'h4, 30'h5, 30'h6, 30'h7};
      alp = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h200, 10'h200, 10'h200, 10'h200};
      beat(pix[0], 1'b1, 1'b0);
      checks++; if (stream_out_data !== {alp[0], pix[0]}) begin
         $display("FAIL opa_pre_write: got %h expected %h", stream_out_data, {alp[0], pix[0]}); failures++; end
      csr_write(2'd2, 32'h200);
      for (int i = 1; i < 7; i++) begin
         // The sop beat of the next frame coincides with a new opacity write that must not apply yet.
         if (i == 5) begin chipselect = 1'b1; write = 1'b1; address = 2'd2; writedata = 32'h100; end
         beat(pix[i], i == 3 || i == 5, i == 2 || i == 4);
         chipselect = 1'b0; write = 1'b0;
         checks++; if (stream_out_data !== {alp[i], pix[i]}) begin
            $display("FAIL opa_beat%0d: got %h expected %h", i, stream_out_data, {alp[i], pix[i]}); failures++; end
      end
      beat(30'h8, 1'b0, 1'b1);
      beat(30'h9, 1'b1, 1'b1);
      checks++; if (stream_out_data !== {10'h100, 30'h9}) begin
         $display("FAIL opa_next_frame_new: got %h expected %h", stream_out_data, {10'h100, 30'h9}); failures++; end
      csr_read(2'd2, rd);
      checks++; if (rd !== 32'h100) begin $display("FAIL opa_readback: got %h expected 100", rd); failures++; end
   endtask

   task automatic test_backpressure();
      logic [29:0] pix [8];
      logic [9:0]  alp [8];
      logic [41:0] exp_q [$];
      logic [41:0] exp_v;
      logic [39:0] held;
      logic        held_v;
      int          sent;
      int          got;
      pix = '{30'h1000001, 30'h0ABCDEF, 30'h3FFFFFFF, 30'h0ABCDEE,
              30'h0ABCDEF, 30'h2000000, 30'h0000000, 30'h0ABCDEF};
      alp = '{10'h2AA, 10'h000, 10'h2AA, 10'h2AA, 10'h000, 10'h2AA, 10'h2AA, 10'h000};
      csr_write(2'd0, 32'h3);
      csr_write(2'd1, 32'h0ABCDEF);
      csr_write(2'd2, 32'h2AA);
      sent = 0; got = 0; held_v = 1'b0; held = '0;
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
         stream_out_ready = (cyc < 6) ? 1'b0 : ((cyc % 3) != 2);
         if (sent < 8) begin
            stream_in_valid         = 1'b1;
            stream_in_data          = pix[sent];
            stream_in_startofpacket = (sent == 0);
            stream_in_endofpacket   = (sent == 7);
         end else begin
            stream_in_valid = 1'b0;
         end
         @(negedge clk);
         if (held_v) begin
            checks++; if (stream_out_valid !== 1'b1 || stream_out_data !== held) begin
               $display("FAIL bp_hold_cyc%0d: got %b/%h expected 1/%h", cyc, stream_out_valid, stream_out_data, held); failures++; end
         end
         if (stream_out_valid && !stream_out_ready) begin
            checks++; if (stream_in_ready !== 1'b0) begin
               $display("FAIL bp_in_ready_cyc%0d: got %b expected 0", cyc, stream_in_ready); failures++; end
         end
         if (stream_out_valid && stream_out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL bp_extra_beat: got %h expected none", stream_out_data); failures++;
            end else begin
               exp_v = exp_q.pop_front();
               if ({stream_out_startofpacket, stream_out_endofpacket, stream_out_data} !== exp_v) begin
                  $display("FAIL bp_beat%0d: got %h expected %h", got,
                           {stream_out_startofpacket, stream_out_endofpacket, stream_out_data}, exp_v); failures++; end
            end
            got++;
         end
         held_v = stream_out_valid && !stream_out_ready;
         held   = stream_out_data;
         if (stream_in_valid && stream_in_ready) begin
            exp_q.push_back({sent == 0, sent == 7, alp[sent], pix[sent]});
            sent++;
         end
         @(posedge clk); #1;
      end
      stream_in_valid = 1'b0; stream_in_startofpacket = 1'b0; stream_in_endofpacket = 1'b0;
      stream_out_ready = 1'b1;
      checks++; if (got !== 8 || exp_q.size() !== 0) begin
         $display("FAIL bp_count: got %0d beats (%0d left) expected 8 (0 left)", got, exp_q.size()); failures++; end
      @(posedge clk); #1;
   endtask

   task automatic test_ctrl_modes();
      csr_write(2'd0, 32'h1);
      beat(30'h0ABCDEF, 1'b1, 1'b1);
      checks++; if (stream_out_data !== {10'h3FF, 30'h0ABCDEF}) begin
         $display("FAIL ctrl_blend_off: got %h expected %h", stream_out_data, {10'h3FF, 30'h0ABCDEF}); failures++; end
      csr_write(2'd0, 32'h2);
      csr_write(2'd2, 32'h155);
      beat(30'h0ABCDEF, 1'b1, 1'b1);
      checks++; if (stream_out_data !== {10'h155, 30'h0ABCDEF}) begin
         $display("FAIL ctrl_key_off: got %h expected %h", stream_out_data, {10'h155, 30'h0ABCDEF}); failures++; end
      csr_write(2'd0, 32'h3);
      beat(30'h0ABCDEF, 1'b1, 1'b1);
      checks++; if (stream_out_data !== {10'h000, 30'h0ABCDEF}) begin
         $display("FAIL ctrl_key_hit: got %h expected %h", stream_out_data, {10'h000, 30'h0ABCDEF}); failures++; end
   endtask

   task automatic test_status();
      logic [31:0] rd;
      csr_write(2'd3, 32'h0);
      for (int f = 0; f < 3; f++) begin
         beat(30'h1, 1'b1, 1'b0);
         beat(30'h2, 1'b0, 1'b1);
      end
      csr_read(2'd3, rd);
      checks++; if (rd !== 32'h0003_0000) begin $display("FAIL status_three: got %h expected 00030000", rd); failures++; end
      beat(30'h1, 1'b1, 1'b0);
      csr_read(2'd3, rd);
      checks++; if (rd !== 32'h0003_0001) begin $display("FAIL status_in_frame: got %h expected 00030001", rd); failures++; end
      chipselect = 1'b1; write = 1'b1; address = 2'd3; writedata = 32'h0;
      beat(30'h2, 1'b0, 1'b1);
      chipselect = 1'b0; write = 1'b0;
      csr_read(2'd3, rd);
      checks++; if (rd !== 32'h0) begin $display("FAIL status_clear_wins: got %h expected 0", rd); failures++; end
      beat(30'h3, 1'b1, 1'b1);
      csr_read(2'd3, rd);
      checks++; if (rd !== 32'h0001_0000) begin $display("FAIL status_single_beat: got %h expected 00010000", rd); failures++; end
   endtask

   task automatic test_reset_midframe();
      logic [31:0] rd;
      csr_write(2'd2, 32'h0AA);
      beat(30'h11, 1'b1, 1'b0);
      stream_in_valid = 1'b1; stream_in_data = 30'h22;
      reset = 1'b0;
      #2;
      checks++; if (stream_out_valid !== 1'b0 || stream_out_data !== 40'h0) begin
         $display("FAIL rst_async: got %b/%h expected 0/0", stream_out_valid, stream_out_data); failures++; end
      @(posedge clk); #1;
      reset = 1'b1; stream_in_valid = 1'b0;
      checks++; if (stream_out_valid !== 1'b0) begin
         $display("FAIL rst_no_partial: got %b expected 0", stream_out_valid); failures++; end
      csr_read(2'd2, rd);
      checks++; if (rd !== 32'h3FF) begin $display("FAIL rst_opacity_default: got %h expected 3ff", rd); failures++; end
      csr_read(2'd3, rd);
      checks++; if (rd !== 32'h0) begin $display("FAIL rst_status: got %h expected 0", rd); failures++; end
      beat(30'h0, 1'b1, 1'b0);
      checks++; if (stream_out_data !== 40'h0) begin
         $display("FAIL rst_clean_beat0: got %h expected 0", stream_out_data); failures++; end
      beat(30'h155, 1'b0, 1'b1);
      checks++; if (stream_out_data !== {10'h3FF, 30'h155}) begin
         $display("FAIL rst_clean_beat1: got %h expected %h", stream_out_data, {10'h3FF, 30'h155}); failures++; end
   endtask

   initial begin
      reset = 1'b0;
      stream_in_data = '0; stream_in_startofpacket = 1'b0; stream_in_endofpacket = 1'b0;
      stream_in_empty = 2'h0; stream_in_valid = 1'b0; stream_out_ready = 1'b1;
      address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0; writedata = '0;
      test_reset();
      test_default_frame();
      test_opacity_midframe();
      test_backpressure();
      test_ctrl_modes();
      test_status();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
